// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//
// This block arbitrates and sequences writes into a register file that has a
// single write port. Two writeback requesters feed it: requester 0 is execute
// and requester 1 is memory. Each requester hands its write over through a
// valid/ready handshake into its own one-entry holding slot. Every cycle the
// block picks one held write, oldest first, and registers it onto the
// wen/addr/data write port.
//
// Parameters
//   addr_width_p : register address width (2**addr_width_p registers)
//   W1           : data word width
//
// Ports
//   clk            : clock, all state updates on posedge
//   reset_n        : asynchronous active-low reset
//   req_valid_i    : per-requester write request valid
//   req_addr_i     : per-requester address, requester r at [r*addr_width_p +: addr_width_p]
//   req_data_i     : per-requester data, requester r at [r*W1 +: W1]
//   req_ready_o    : per-requester ready; a transfer happens on valid&ready at posedge
//   wen_o          : register file write enable (registered)
//   waddr_o        : register file write address (registered)
//   wdata_o        : register file write data (registered)
//   busy_o         : high while any slot is full or wen_o is high
//
// Optional build macro RF_WB_BYPASS_EN adds a forwarding lookup port:
//   lookup_addr_i  : address to search for in the in-flight writes
//   hit_o          : the lookup matched a full slot or the live output register
//   hit_data_o     : the youngest matching data, or 0 when there is no hit
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int addr_width_p = 6,
    parameter int W1           = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [1:0]                req_valid_i,
    input  logic [2*addr_width_p-1:0] req_addr_i,
    input  logic [2*W1-1:0]           req_data_i,
    output logic [1:0]                req_ready_o,
    output logic                      wen_o,
    output logic [addr_width_p-1:0]   waddr_o,
    output logic [W1-1:0]             wdata_o,
    output logic                      busy_o
`ifdef RF_WB_BYPASS_EN
    ,
    input  logic [addr_width_p-1:0]   lookup_addr_i,
    output logic                      hit_o,
    output logic [W1-1:0]             hit_data_o
`endif
);

    // Holding slots
    logic [1:0]              full_q, full_d;
    logic [1:0]              old_q, old_d;
    logic [addr_width_p-1:0] addr_q [2];
    logic [addr_width_p-1:0] addr_d [2];
    logic [W1-1:0]           data_q [2];
    logic [W1-1:0]           data_d [2];

    // Round-robin tie breaker: the index of the requester that wins the next tie
    logic                    ptr_q, ptr_d;

    // Registered write port
    logic                    wen_q, wen_d;
    logic [addr_width_p-1:0] waddr_q, waddr_d;
    logic [W1-1:0]           wdata_q, wdata_d;

    logic [1:0]              grant;
    logic                    tie;
    logic [1:0]              load;

    // -------------------------------------------------------------------------
    // Arbitration. When both slots are full and their ages differ, the older
    // slot wins. When both are full and equally old, the pointer decides.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in an always_comb gets a default first,
        // so there is no path that keeps an old value and infers a latch.
        grant = 2'b00;
        tie   = 1'b0;
        case (full_q)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                if (old_q[0] != old_q[1]) begin
                    grant = old_q;
                end else begin
                    tie   = 1'b1;
                    grant = ptr_q ? 2'b10 : 2'b01;
                end
            end
            default: grant = 2'b00;
        endcase
    end

    // A slot can accept a new write when it is empty, or when it drains at
    // this same edge. Ready does not depend on req_valid_i.
    assign req_ready_o = ~full_q | grant;
    assign load        = req_valid_i & req_ready_o;

    // -------------------------------------------------------------------------
    // Next state for the slots, the age bits, the pointer and the output stage
    // -------------------------------------------------------------------------
    always_comb begin
        full_d  = full_q;
        old_d   = 2'b00;
        addr_d  = addr_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        for (int r = 0; r < 2; r++) begin
            full_d[r] = load[r] | (full_q[r] & ~grant[r]);
            // Address and data are only captured on a real transfer, so
            // anything on the buses while valid is low never reaches state.
            if (load[r]) begin
                addr_d[r] = req_addr_i[r*addr_width_p +: addr_width_p];
                data_d[r] = req_data_i[r*W1 +: W1];
            end
        end

        // The age bit is set only on a slot that stays full while the other
        // slot loads. A freshly loaded slot is never the older one. When both
        // slots load at once, both bits clear and the pointer breaks the tie.
        for (int r = 0; r < 2; r++) begin
            if (load[r]) begin
                old_d[r] = 1'b0;
            end else if (full_d[r] && load[1-r]) begin
                old_d[r] = 1'b1;
            end else if (full_d[r] && full_d[1-r]) begin
                old_d[r] = old_q[r];
            end else begin
                old_d[r] = 1'b0;
            end
        end

        // On a tie the pointer moves to the requester that lost.
        if (tie) begin
            ptr_d = grant[0];
        end

        if (grant[1]) begin
            wen_d   = 1'b1;
            waddr_d = addr_q[1];
            wdata_d = data_q[1];
        end else if (grant[0]) begin
            wen_d   = 1'b1;
            waddr_d = addr_q[0];
            wdata_d = data_q[0];
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_q  <= 2'b00;
            old_q   <= 2'b00;
            ptr_q   <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            // NOTE: the slot storage is cleared on reset as well, so a slot
            // can never present stale contents after reset is released.
            for (int r = 0; r < 2; r++) begin
                addr_q[r] <= '0;
                data_q[r] <= '0;
            end
        end else begin
            // NOTE: state updates use non-blocking assignments, so every flop
            // samples the values from before the edge and the order of these
            // statements does not matter.
            full_q  <= full_d;
            old_q   <= old_d;
            ptr_q   <= ptr_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign wen_o   = wen_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;
    assign busy_o  = (|full_q) | wen_q;

`ifdef RF_WB_BYPASS_EN
    // -------------------------------------------------------------------------
    // Forwarding lookup. The youngest data wins: a non-old full slot first,
    // then an old full slot, then the live output register. The sources are
    // checked from lowest to highest priority, and each later match
    // overwrites the earlier one. When both slots are equally young, slot 0
    // is checked last and so wins.
    // -------------------------------------------------------------------------
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        if (wen_q && (waddr_q == lookup_addr_i)) begin
            hit_o      = 1'b1;
            hit_data_o = wdata_q;
        end
        for (int r = 1; r >= 0; r--) begin
            if (full_q[r] && old_q[r] && (addr_q[r] == lookup_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = data_q[r];
            end
        end
        for (int r = 1; r >= 0; r--) begin
            if (full_q[r] && !old_q[r] && (addr_q[r] == lookup_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = data_q[r];
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter
//
// This is a scoreboard bench for rf_wb_arbiter.
//
// The reference model keeps two held requests, each tagged with the cycle in
// which it was loaded. The model grants the earliest-loaded request, and on
// equal load times it uses a round-robin pointer. Every grant pushes the
// expected write, together with the cycle it must appear in, into a queue.
// An independent monitor compares every write port cycle against that queue.
// Requests come from per-requester queues of directed and random writes.
//
// Build with +define+RF_WB_BYPASS_EN to also exercise the lookup port.
// -----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;

    logic            clk;
    logic            reset_n;
    logic [1:0]      req_valid_i;
    logic [2*AW-1:0] req_addr_i;
    logic [2*DW-1:0] req_data_i;
    logic [1:0]      req_ready_o;
    logic            wen_o;
    logic [AW-1:0]   waddr_o;
    logic [DW-1:0]   wdata_o;
    logic            busy_o;
`ifdef RF_WB_BYPASS_EN
    logic [AW-1:0]   lookup_addr_i;
    logic            hit_o;
    logic [DW-1:0]   hit_data_o;
`endif

    rf_wb_arbiter #(.addr_width_p(AW), .W1(DW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid_i (req_valid_i),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .wen_o       (wen_o),
        .waddr_o     (waddr_o),
        .wdata_o     (wdata_o),
        .busy_o      (busy_o)
`ifdef RF_WB_BYPASS_EN
        ,
        .lookup_addr_i (lookup_addr_i),
        .hit_o         (hit_o),
        .hit_data_o    (hit_data_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    req_t rq [2][$];   // pending requests per requester
    exp_t sb [$];      // expected writes, in order

    // Reference model state
    bit   m_full [2];
    req_t m_slot [2];
    int   m_t    [2];
    bit   m_ptr;
    bit   m_wen;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_writes = 0;
    int            last_wcycle = 0;
    logic [AW-1:0] last_waddr = '0;
    logic [DW-1:0] last_wdata = '0;
    logic [DW-1:0] rf7 = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string msg);
        n_checks++;
        n_fail++;
        $display("FAIL %s (time %0t)", msg, $time);
    endtask

    // Monitor: every cycle with wen_o high must match the head of the
    // scoreboard. Cycles without a write must hold address and data.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                last_waddr = '0;
                last_wdata = '0;
            end else if (wen_o) begin
                n_writes++;
                last_wcycle = cyc;
                if (sb.size() == 0) begin
                    fail_now($sformatf("unexpected_write: got addr %0h data %0h, expected no write",
                                       waddr_o, wdata_o));
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", 64'(waddr_o), 64'(e.addr));
                    check("wr_data", 64'(wdata_o), 64'(e.data));
                    check("wr_cycle", 64'(cyc), 64'(e.due));
                end
                last_waddr = waddr_o;
                last_wdata = wdata_o;
                if (waddr_o == AW'(7)) rf7 = wdata_o;
            end else begin
                check("hold_addr", 64'(waddr_o), 64'(last_waddr));
                check("hold_data", 64'(wdata_o), 64'(last_wdata));
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    fail_now($sformatf("missing_write: got no write, expected addr %0h data %0h",
                                       e.addr, e.data));
                end
            end
        end
    end

    // One cycle of model and stimulus. At the negedge, check ready and busy,
    // drive the request heads, and predict this cycle's grant and next state.
    task automatic step();
        int         g;
        logic [1:0] rdy;
        bit         ld [2];
        @(negedge clk);
        g = -1;
        if (m_full[0] && m_full[1]) begin
            if (m_t[0] < m_t[1])      g = 0;
            else if (m_t[1] < m_t[0]) g = 1;
            else begin
                g     = m_ptr ? 1 : 0;
                m_ptr = (g == 0);
            end
        end else if (m_full[0]) g = 0;
        else if (m_full[1])     g = 1;

        for (int r = 0; r < 2; r++) rdy[r] = !m_full[r] || (g == r);
        check("ready", 64'(req_ready_o), 64'(rdy));
        check("busy", 64'(busy_o), 64'(m_full[0] | m_full[1] | m_wen));

        for (int r = 0; r < 2; r++) begin
            if (rq[r].size() > 0) begin
                req_valid_i[r]            = 1'b1;
                req_addr_i[r*AW +: AW]    = rq[r][0].addr;
                req_data_i[r*DW +: DW]    = rq[r][0].data;
                ld[r]                     = rdy[r];
            end else begin
                req_valid_i[r]            = 1'b0;
                req_addr_i[r*AW +: AW]    = AW'($urandom);
                req_data_i[r*DW +: DW]    = $urandom;
                ld[r]                     = 1'b0;
            end
        end

        if (g >= 0) begin
            sb.push_back('{addr: m_slot[g].addr, data: m_slot[g].data, due: cyc + 1});
            m_full[g] = 1'b0;
        end
        for (int r = 0; r < 2; r++) begin
            if (ld[r]) begin
                m_slot[r] = rq[r].pop_front();
                m_full[r] = 1'b1;
                m_t[r]    = cyc;
            end
        end
        m_wen = (g >= 0);
    endtask

    task automatic do_reset();
        #2;
        reset_n     = 1'b0;
        req_valid_i = 2'b00;
        #1;
        check("rst_wen", 64'(wen_o), 64'(0));
        check("rst_ready", 64'(req_ready_o), 64'(2'b11));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_waddr", 64'(waddr_o), 64'(0));
        check("rst_wdata", 64'(wdata_o), 64'(0));
        rq[0].delete();
        rq[1].delete();
        sb.delete();
        m_full = '{1'b0, 1'b0};
        m_ptr  = 1'b0;
        m_wen  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((rq[0].size() > 0 || rq[1].size() > 0 || m_full[0] || m_full[1] ||
                m_wen || sb.size() > 0) && k < budget) begin
            step();
            k++;
        end
        if (k >= budget) fail_now("drain_timeout: writes still pending after cycle budget");
    endtask

    initial begin
        int t0;
        int w0;
        int k;
        reset_n     = 1'b0;
        req_valid_i = 2'b00;
        req_addr_i  = '0;
        req_data_i  = '0;
`ifdef RF_WB_BYPASS_EN
        lookup_addr_i = '0;
`endif
        do_reset();

        // Single write latency: accepted at edge N, written in cycle N+2
        rq[0].push_back('{addr: AW'(5), data: 32'hDEADBEEF});
        step();
        t0 = cyc;
        drain(20);
        check("latency_cycle", 64'(last_wcycle), 64'(t0 + 2));
        check("latency_data", 64'(last_wdata), 64'(32'hDEADBEEF));
        check("latency_addr", 64'(last_waddr), 64'(5));

        // Lone requester streaming addresses 1..4
        w0 = n_writes;
        for (int i = 1; i <= 4; i++) rq[0].push_back('{addr: AW'(i), data: $urandom});
        drain(20);
        check("stream_count", 64'(n_writes - w0), 64'(4));

        // Both requesters valid every cycle from reset
        do_reset();
        w0 = n_writes;
        for (int n = 0; n < 4; n++) begin
            rq[0].push_back('{addr: AW'(10 + n), data: 32'h1000 + n});
            rq[1].push_back('{addr: AW'(20 + n), data: 32'h2000 + n});
        end
        drain(30);
        check("both_count", 64'(n_writes - w0), 64'(8));

        // Same address from both sides; the older slot (requester 1) is
        // written first, so the later write of 0x2 must be the one that lands
        do_reset();
        rq[0].push_back('{addr: AW'(1), data: 32'hA1});
        rq[0].push_back('{addr: AW'(3), data: 32'hA3});
        rq[0].push_back('{addr: AW'(7), data: 32'h2});
        rq[1].push_back('{addr: AW'(2), data: 32'hB2});
        rq[1].push_back('{addr: AW'(7), data: 32'h1});
        drain(30);
        check("same_addr_final", 64'(rf7), 64'(32'h2));

        // Reset while both slots are full and a write is on the port
        for (int i = 0; i < 6; i++) begin
            rq[0].push_back('{addr: AW'(40 + i), data: $urandom});
            rq[1].push_back('{addr: AW'(50 + i), data: $urandom});
        end
        k = 0;
        while (!(m_full[0] && m_full[1] && m_wen) && k < 20) begin
            step();
            k++;
        end
        if (k >= 20) fail_now("midreset_setup: both slots never full with wen");
        do_reset();
        w0 = n_writes;
        rq[1].push_back('{addr: AW'(33), data: 32'h5A5A5A5A});
        drain(20);
        check("post_reset_count", 64'(n_writes - w0), 64'(1));
        check("post_reset_data", 64'(last_wdata), 64'(32'h5A5A5A5A));

`ifdef RF_WB_BYPASS_EN
        // Slot 0 holds 9/0xAA while the output register holds 9/0xBB
        rq[1].push_back('{addr: AW'(9), data: 32'hBB});
        step();
        rq[0].push_back('{addr: AW'(9), data: 32'hAA});
        step();
        step();
        lookup_addr_i = AW'(9);
        #1;
        check("bypass_hit", 64'(hit_o), 64'(1));
        check("bypass_data", 64'(hit_data_o), 64'(32'hAA));
        lookup_addr_i = AW'(3);
        #1;
        check("bypass_miss", 64'(hit_o), 64'(0));
        check("bypass_miss_data", 64'(hit_data_o), 64'(0));
        drain(20);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (rq[r].size() < 3 && $urandom_range(0, 1) == 1)
                    rq[r].push_back('{addr: AW'($urandom_range(0, 63)), data: $urandom});
            end
            step();
        end
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
